// File: rtl/ycrcb_pkg.sv
// Shared constants and pixel/sideband types for the YCrCb conversion path.
package ycrcb_pkg;

    // Bits per colour component, both RGB in and YCrCb out.
    localparam int DATA_W   = 8;
    // Converter latency in clock edges from input sample to valid result.
    localparam int CONV_LAT = 3;

    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] cr;
        logic [DATA_W-1:0] cb;
    } ycrcb_t;

    typedef struct packed {
        logic sof;
        logic eol;
    } sb_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on rd_data while not empty. DEPTH must be a power of two so the pointers
// wrap naturally. A write is accepted when not full, or when full and a read
// happens on the same edge.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ycrcb_stream_ctrl.sv
// Stream controller around the fixed-latency, non-stallable RGB->YCrCb
// converter. A credit counter reserves an output FIFO slot for every accepted
// pixel, so results emerging from the converter always have somewhere to go
// even while the consumer stalls. Valid/sideband ride alongside the converter
// in a delay line.
//
// Handshake: a transfer happens on an edge where valid and ready are both
// high; a producer holding valid keeps its data stable until that edge, and
// ready never depends combinationally on the partner's valid.
module ycrcb_stream_ctrl #(
    parameter int DATA_W     = ycrcb_pkg::DATA_W,
    parameter int CONV_LAT   = ycrcb_pkg::CONV_LAT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_r,
    input  logic [DATA_W-1:0] s_g,
    input  logic [DATA_W-1:0] s_b,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic [DATA_W-1:0] conv_r,
    output logic [DATA_W-1:0] conv_g,
    output logic [DATA_W-1:0] conv_b,
    input  logic [DATA_W-1:0] conv_y,
    input  logic [DATA_W-1:0] conv_cr,
    input  logic [DATA_W-1:0] conv_cb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_y,
    output logic [DATA_W-1:0] m_cr,
    output logic [DATA_W-1:0] m_cb,
    output logic              m_sof,
    output logic              m_eol,
    output logic [15:0]       frame_cnt,
    output logic              idle,
    output logic              ovf_err
);

    import ycrcb_pkg::*;

    localparam int FW    = 3 * DATA_W + 2;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic              in_fire;
    logic              m_fire;
    logic [CNT_W-1:0]  reserved;
    logic [CONV_LAT:0] dl_valid;
    sb_t  [CONV_LAT:0] dl_sb;
    logic              fifo_wr;
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Ready is a function of registered state only. Holding it low while
    // rst_n is low keeps every output at zero during reset; the full term is
    // implied by the credit limit and only acts as a backstop.
    assign s_ready = rst_n & enable & (reserved < DEPTH_C) & ~fifo_full;
    assign in_fire = s_valid & s_ready;
    assign m_valid = ~fifo_empty;
    assign m_fire  = m_valid & m_ready;
    assign idle    = (reserved == '0);

    // Head-of-FIFO presentation; zeroed when nothing is buffered.
    assign {m_y, m_cr, m_cb, m_sof, m_eol} = m_valid ? fifo_rdata : '0;

    assign fifo_wr    = dl_valid[CONV_LAT];
    assign fifo_wdata = {conv_y, conv_cr, conv_cb, dl_sb[CONV_LAT]};

    // Credit counter: one slot per pixel from acceptance until it leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reserved <= '0;
        end else begin
            case ({in_fire, m_fire})
                2'b10:   reserved <= reserved + CNT_W'(1);
                2'b01:   reserved <= reserved - CNT_W'(1);
                default: reserved <= reserved;
            endcase
        end
    end

    // Converter drive registers: updated only when a pixel is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_r <= '0;
            conv_g <= '0;
            conv_b <= '0;
        end else if (in_fire) begin
            conv_r <= s_r;
            conv_g <= s_g;
            conv_b <= s_b;
        end
    end

    // Valid/sideband delay line matching converter latency; never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid <= '0;
            dl_sb    <= '0;
        end else begin
            dl_valid <= {dl_valid[CONV_LAT-1:0], in_fire};
            dl_sb    <= {dl_sb[CONV_LAT-1:0], sb_t'{sof: s_sof, eol: s_eol}};
        end
    end

    // Frame counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            ovf_err   <= 1'b0;
        end else begin
            if (m_fire && m_sof) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (fifo_wr && (fifo_count == DEPTH_C)) begin
                ovf_err <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (m_ready),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: doc/ycrcb_stream_ctrl.md
Name: ycrcb_stream_ctrl

Overview:
Stream controller that sequences pixels through the fixed-latency, non-stallable rgb_to_ycrcb converter. It accepts an RGB valid/ready stream with frame/line sideband and feeds the converter. Sideband and valid travel alongside in a delay line, and results land in an output FIFO so a downstream stall never loses a pixel. It sits between the camera/pixel source and the downstream YCrCb consumers (thresholding, binarisation).

Parameters:
DATA_W, 8, bits per colour component (in and out)
CONV_LAT, 3, converter latency in clock edges from input sample to valid output
FIFO_DEPTH, 8, output FIFO entries and credit limit (power of two, >= CONV_LAT+1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = accept new pixels; 0 = stop accepting and drain in-flight pixels
s_valid  in  1  input pixel valid
s_ready  out  1  controller can accept a pixel
s_r / s_g / s_b  in  DATA_W each  input RGB
s_sof  in  1  first pixel of frame
s_eol  in  1  last pixel of line
conv_r / conv_g / conv_b  out  DATA_W each  registered drive to converter
conv_y / conv_cr / conv_cb  in  DATA_W each  converter results
m_valid  out  1  output pixel valid (FIFO non-empty)
m_ready  in  1  downstream accepts
m_y / m_cr / m_cb  out  DATA_W each  output YCrCb
m_sof / m_eol  out  1 each  sideband aligned with output pixel
frame_cnt  out  16  count of m_sof handshakes, wraps 0xFFFF->0
idle  out  1  no pixel reserved, in flight or buffered
ovf_err  out  1  sticky: FIFO write while full (must never occur)

Behaviour:
- Reset: async on rst_n low. All outputs are 0 except idle=1. The delay line, FIFO pointers and reserved counter clear. Reset mid-operation discards all in-flight and buffered pixels; no partial output after release.
- in_fire = s_valid & s_ready; m_fire = m_valid & m_ready.
- Credit counter `reserved` (0..FIFO_DEPTH): +1 on in_fire, -1 on m_fire, unchanged when both or neither occur.
- s_ready = enable & (reserved < FIFO_DEPTH). This is a registered-state function only, with no combinational path from m_ready or s_valid. Because of the credit limit, the FIFO can never overflow.
- On in_fire, conv_r/g/b <= s_r/g/b. Otherwise they hold their last value. The converter samples them every edge; the result is ignored unless tagged valid.
- Delay line, CONV_LAT+1 stages of {valid, sof, eol}:
  - Stage 0 loads {in_fire, s_sof, s_eol} every edge and shifts every edge, never stalled.
  - When the last stage is valid, {conv_y, conv_cr, conv_cb, sof, eol} are written into the FIFO on that edge.
- Latency: in_fire at edge N -> FIFO write at edge N+CONV_LAT+1 -> m_valid high after that edge (4 edges by default when the FIFO is empty).
- FIFO is first-word-fall-through: m_* present the head entry. m_* hold stable while m_valid & !m_ready. m_y/cr/cb/sof/eol are don't-care when m_valid=0.
- Simultaneous write and read, including on a full FIFO: both take effect, occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- frame_cnt increments on m_fire & m_sof.
- idle = (reserved == 0).
- enable falling: s_ready drops in the same cycle. In-flight pixels still complete and are delivered. enable has no effect on the delay line or FIFO.
- ovf_err sets on a FIFO write while occupancy == FIFO_DEPTH. It clears only on reset.
- Sideband is passed through unchecked; sof/eol ordering errors are the source's responsibility.

Decomposition:
- Package ycrcb_pkg:
  - DATA_W and CONV_LAT constants (the converter uses the same CONV_LAT).
  - Packed pixel typedefs: rgb_t {r,g,b} and ycrcb_t {y,cr,cb}.
  - Sideband typedef sb_t {sof,eol}.
- One sub-module, sync_fifo_fwft: parameterised width/depth, first-word-fall-through, with full/empty/count outputs and the same clk/rst_n. It is reused elsewhere in the pipeline.
- The delay line and credit counter stay in the top module.

Test Plan:
- Reset: rst_n low with random inputs -> s_ready=0, m_valid=0, frame_cnt=0, idle=1, ovf_err=0. After release with enable=1 -> s_ready=1 on the first cycle.
- Single pixel: behavioural converter model (CONV_LAT=3, y=r^0x5A). Send R=0x80, sof=1, eol=1 at edge N, m_ready=1 -> m_valid rises after edge N+4 with m_y=0xDA, m_sof=1, m_eol=1; frame_cnt becomes 1 on m_fire; idle returns to 1.
- Backpressure: m_ready=0, s_valid=1 continuously with an incrementing R -> exactly 8 accepts, then s_ready=0. Raise m_ready -> 8 pixels out in order, no duplicates or drops, ovf_err=0.
- Full plus simultaneous read: reserved=8, m_ready=1 for one cycle -> s_ready=0 in that cycle, 1 in the next. Accept and pop in the same cycle -> reserved stays 7.
- Enable drop: stream 20 pixels, drop enable after the 10th accept -> s_ready=0 immediately; exactly 10 pixels are output; idle=1 afterwards.
- Reset mid-flight: assert rst_n low with 3 pixels in the delay line and 5 in the FIFO -> after release no m_valid until new input, frame_cnt=0, first output equals the first post-reset pixel.
